// File: rtl/capture_accumulator.sv
// capture_accumulator: triggered multi-record waveform accumulator with averaged valid/ready drain
module capture_accumulator #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 128,
    parameter  int EVT_W  = 8,
    localparam int ACC_W  = DATA_W + EVT_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig,
    input  logic [EVT_W-1:0]  num_events,
    input  logic [3:0]        avg_shift,
    input  logic              cont,
    output logic [ACC_W-1:0]  dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              busy,
    output logic [EVT_W-1:0]  event_cnt,
    output logic              trig_missed
);
    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, CHECK, DRAIN} state_t;
    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [EVT_W-1:0]  num_q, event_cnt_q;
    logic [3:0]        shift_q;
    logic              cont_q, fetch_done_q, trig_missed_q;
    logic [ACC_W-1:0]  dout_q;
    logic              dout_valid_q, dout_last_q;
    logic [ACC_W-1:0]  acc_q [DEPTH];
    logic [EVT_W-1:0]  target_d, cnt_next_d;
    logic [ACC_W-1:0]  wr_word_d, rd_word_d;
    logic              last_addr_d, cap_fire_d, load_d, xfer_d;
    // Next-state helpers: first record overwrites, later records add; drain prefetches one word ahead
    always_comb begin
        target_d    = (num_q == '0) ? EVT_W'(1) : num_q;
        cnt_next_d  = event_cnt_q + EVT_W'(1);
        last_addr_d = addr_q == ADDR_W'(DEPTH - 1);
        cap_fire_d  = state_q == CAPTURE && din_valid && !abort;
        wr_word_d   = ((event_cnt_q == '0) ? '0 : acc_q[addr_q]) + ACC_W'(din);
        rd_word_d   = acc_q[addr_q] >> shift_q;
        load_d      = !fetch_done_q && (!dout_valid_q || dout_ready);
        xfer_d      = dout_valid_q && dout_ready;
        dout        = dout_q;
        dout_valid  = dout_valid_q;
        dout_last   = dout_last_q;
        busy        = state_q != IDLE;
        event_cnt   = event_cnt_q;
        trig_missed = trig_missed_q;
    end
    // Accumulator memory write, one slot per qualified capture sample
    always_ff @(posedge clk) begin
        if (cap_fire_d) acc_q[addr_q] <= wr_word_d;
    end
    // Run control FSM with record addressing and registered drain output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            num_q         <= '0;
            shift_q       <= '0;
            cont_q        <= 1'b0;
            fetch_done_q  <= 1'b0;
            event_cnt_q   <= '0;
            trig_missed_q <= 1'b0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            dout_last_q   <= 1'b0;
        end else begin
            if (trig && (state_q == CAPTURE || state_q == DRAIN)) trig_missed_q <= 1'b1;
            if (abort) begin
                state_q      <= IDLE;
                dout_valid_q <= 1'b0;
                dout_last_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (arm) begin
                        num_q         <= num_events;
                        shift_q       <= avg_shift;
                        cont_q        <= cont;
                        event_cnt_q   <= '0;
                        trig_missed_q <= 1'b0;
                        state_q       <= ARMED;
                    end
                    ARMED: begin
                        addr_q <= '0;
                        if (trig) state_q <= CAPTURE;
                    end
                    CAPTURE: if (din_valid) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        if (last_addr_d) state_q <= CHECK;
                    end
                    CHECK: begin
                        event_cnt_q  <= cnt_next_d;
                        addr_q       <= '0;
                        fetch_done_q <= 1'b0;
                        state_q      <= (cnt_next_d == target_d) ? DRAIN : ARMED;
                    end
                    DRAIN: begin
                        if (load_d) begin
                            dout_q       <= rd_word_d;
                            dout_last_q  <= last_addr_d;
                            dout_valid_q <= 1'b1;
                            addr_q       <= addr_q + ADDR_W'(1);
                            fetch_done_q <= last_addr_d;
                        end else if (xfer_d) begin
                            dout_valid_q <= 1'b0;
                        end
                        if (xfer_d && dout_last_q) begin
                            state_q      <= cont_q ? ARMED : IDLE;
                            dout_valid_q <= 1'b0;
                            dout_last_q  <= 1'b0;
                            if (cont_q) event_cnt_q <= '0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_capture_accumulator.sv
// tb_capture_accumulator: randomized run-level model check of the capture accumulator
module tb_capture_accumulator;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int EVT_W  = 8;
    localparam int ACC_W  = DATA_W + EVT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              din_valid = 1'b0;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic              trig = 1'b0;
    logic [EVT_W-1:0]  num_events = '0;
    logic [3:0]        avg_shift = '0;
    logic              cont = 1'b0;
    logic [ACC_W-1:0]  dout;
    logic              dout_valid;
    logic              dout_ready = 1'b0;
    logic              dout_last;
    logic              busy;
    logic [EVT_W-1:0]  event_cnt;
    logic              trig_missed;

    capture_accumulator #(.DATA_W(DATA_W), .DEPTH(DEPTH), .EVT_W(EVT_W)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .arm(arm), .abort(abort),
        .trig(trig), .num_events(num_events), .avg_shift(avg_shift), .cont(cont),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
        .busy(busy), .event_cnt(event_cnt), .trig_missed(trig_missed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    longint exp_q[$];
    bit exp_last_q[$];
    longint got_log[$];
    int rdy_pct = 100;
    bit force_off = 1'b0;

    function automatic void chk(string name, longint got, longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endfunction

    function automatic logic [DATA_W-1:0] gen(int kind, int r, int i);
        case (kind)
            0: return DATA_W'(i);
            1: return DATA_W'(200);
            2: return DATA_W'(10 * (r + 1));
            3: return DATA_W'(255);
            default: return DATA_W'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // downstream ready, randomly throttled
    initial forever begin
        @(posedge clk);
        #1;
        dout_ready = !force_off && ($urandom_range(0, 99) < rdy_pct);
    end

    // output stream checker against the expected-word queue
    logic             prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0, prev_ab = 1'b0;
    logic [ACC_W-1:0] prev_d = '0;
    longint           e_word;
    bit               e_last;
    always @(negedge clk) begin
        if (!rst) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r && !prev_ab) begin
                chk("hold_valid", dout_valid, 1);
                chk("hold_data", dout, prev_d);
                chk("hold_last", dout_last, prev_l);
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 1, 0);
                end else begin
                    e_word = exp_q.pop_front();
                    e_last = exp_last_q.pop_front();
                    chk("dout", dout, e_word);
                    chk("dout_last", dout_last, e_last);
                end
                got_log.push_back(dout);
            end
            prev_v  = dout_valid;
            prev_r  = dout_ready;
            prev_l  = dout_last;
            prev_d  = dout;
            prev_ab = abort;
        end
    end

    task automatic start(input int nev, input int sh, input bit c);
        num_events = EVT_W'(nev);
        avg_shift  = 4'(sh);
        cont       = c;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
        num_events = EVT_W'($urandom_range(0, 255));
        avg_shift  = 4'($urandom_range(0, 15));
        cont       = 1'($urandom_range(0, 1));
        chk("arm_busy", busy, 1);
        chk("arm_event_cnt", event_cnt, 0);
        chk("arm_trig_missed", trig_missed, 0);
    endtask

    // drive nrec records (all of them when nrec<=0) and queue the expected drain
    task automatic batch(input int nev, input int sh, input int kind, input int duty,
                         input int inj, input int nrec);
        longint sum [DEPTH];
        int n_eff, nr, cnt;
        logic [DATA_W-1:0] d;
        bit v;
        n_eff = (nev == 0) ? 1 : nev;
        nr = (nrec > 0) ? nrec : n_eff;
        foreach (sum[i]) sum[i] = 0;
        for (int r = 0; r < nr; r++) begin
            repeat ($urandom_range(0, 2)) tick();
            trig = 1'b1;
            din_valid = 1'($urandom_range(0, 1));
            din = DATA_W'($urandom_range(0, 255));
            tick();
            trig = 1'b0;
            cnt = 0;
            while (cnt < DEPTH) begin
                v = $urandom_range(0, 99) < duty;
                d = v ? gen(kind, r, cnt) : DATA_W'($urandom_range(0, 255));
                din_valid = v;
                din = d;
                trig = (inj == 1 && r == 0 && cnt == 3);
                arm = (inj == 2 && r == 0 && cnt == 3);
                if (v) begin
                    sum[cnt] += longint'(d);
                    cnt++;
                end
                tick();
            end
            din_valid = 1'b0;
            trig = 1'b0;
            arm = 1'b0;
            if (r == n_eff - 1)
                for (int i = 0; i < DEPTH; i++) begin
                    exp_q.push_back((sum[i] >> sh) & ((64'd1 << ACC_W) - 1));
                    exp_last_q.push_back(i == DEPTH - 1);
                end
            tick();
            tick();
            chk("event_cnt", event_cnt, r + 1);
            chk("busy_run", busy, 1);
        end
    endtask

    task automatic wait_drain(input bit c, input int ws0);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            tick();
            t++;
        end
        chk("drain_timeout", t < 3000, 1);
        chk("drain_words", got_log.size() - ws0, DEPTH);
        chk("after_drain_busy", busy, c);
        if (c) chk("cont_event_cnt", event_cnt, 0);
    endtask

    int ws;
    int t;

    initial begin
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_event_cnt", event_cnt, 0);
        chk("rst_trig_missed", trig_missed, 0);
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // single ramp record
        ws = got_log.size();
        start(1, 0, 0);
        batch(1, 0, 0, 100, 0, 0);
        wait_drain(0, ws);
        chk("ramp_first", got_log[ws], 0);
        chk("ramp_last", got_log[ws + DEPTH - 1], 7);
        chk("ramp_event_cnt", event_cnt, 1);

        // four records of 200
        ws = got_log.size();
        start(4, 0, 0);
        batch(4, 0, 1, 100, 0, 0);
        wait_drain(0, ws);
        chk("accum_800", got_log[ws + 5], 800);

        // 10,20,30,40 averaged by 4
        ws = got_log.size();
        start(4, 2, 0);
        batch(4, 2, 2, 100, 0, 0);
        wait_drain(0, ws);
        chk("avg_25", got_log[ws + 2], 25);

        // gapped input with 30% ready
        rdy_pct = 30;
        ws = got_log.size();
        start(3, 1, 0);
        batch(3, 1, 4, 50, 0, 0);
        wait_drain(0, ws);
        rdy_pct = 100;

        // num_events 0 acts as 1
        ws = got_log.size();
        start(0, 0, 0);
        batch(0, 0, 4, 80, 0, 0);
        wait_drain(0, ws);
        chk("nev0_event_cnt", event_cnt, 1);

        // trigger during capture
        ws = got_log.size();
        start(1, 0, 0);
        batch(1, 0, 4, 70, 1, 0);
        wait_drain(0, ws);
        chk("trig_missed_set", trig_missed, 1);

        // arm during capture ignored
        ws = got_log.size();
        start(2, 3, 0);
        batch(2, 3, 4, 100, 2, 0);
        wait_drain(0, ws);

        // full scale, 255 records
        ws = got_log.size();
        start(255, 0, 0);
        batch(255, 0, 3, 100, 0, 0);
        wait_drain(0, ws);
        chk("full_scale", got_log[ws + DEPTH - 1], 65025);

        // abort mid-drain
        rdy_pct = 50;
        ws = got_log.size();
        start(1, 0, 0);
        batch(1, 0, 4, 100, 0, 0);
        t = 0;
        while (got_log.size() < ws + 3 && t < 500) begin
            tick();
            t++;
        end
        chk("abort_wait", t < 500, 1);
        force_off = 1'b1;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", dout_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_event_cnt", event_cnt, 1);
        exp_q.delete();
        exp_last_q.delete();
        force_off = 1'b0;
        rdy_pct = 100;
        tick();

        // fresh run after abort
        ws = got_log.size();
        start(2, 1, 0);
        batch(2, 1, 4, 90, 0, 0);
        wait_drain(0, ws);

        // continuous mode, two runs from one arm
        rdy_pct = 60;
        ws = got_log.size();
        start(2, 0, 1);
        batch(2, 0, 4, 80, 0, 0);
        wait_drain(1, ws);
        ws = got_log.size();
        batch(2, 0, 4, 80, 0, 0);
        wait_drain(1, ws);
        chk("cont_trig_missed", trig_missed, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("cont_abort_busy", busy, 0);
        rdy_pct = 100;

        // async reset mid-capture
        start(3, 0, 0);
        batch(3, 0, 4, 100, 0, 1);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        din_valid = 1'b1;
        din = 8'd9;
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("pre_rst_trig_missed", trig_missed, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_dout", dout, 0);
        chk("arst_valid", dout_valid, 0);
        chk("arst_last", dout_last, 0);
        chk("arst_busy", busy, 0);
        chk("arst_event_cnt", event_cnt, 0);
        chk("arst_trig_missed", trig_missed, 0);
        din_valid = 1'b0;
        exp_q.delete();
        exp_last_q.delete();
        tick();
        rst = 1'b1;
        tick();

        // run after reset
        ws = got_log.size();
        start(1, 0, 0);
        batch(1, 0, 0, 100, 0, 0);
        wait_drain(0, ws);
        chk("post_rst_last", got_log[ws + DEPTH - 1], 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
